// File: rtl/reloj_pkg.sv
// Shared definitions for the clock-control slice: mode encodings and
// field limits used by the set/run logic.
package reloj_pkg;

  typedef enum logic [1:0] {
    MODO_NORMAL  = 2'd0,
    MODO_SET_HOR = 2'd1,
    MODO_SET_MIN = 2'd2,
    MODO_INVALID = 2'd3
  } modo_t;

  localparam logic [5:0] SEG_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Mode sequence driven by the mode button; the spare code falls back to NORMAL.
  function automatic modo_t siguiente_modo(input modo_t actual);
    modo_t sig;
    case (actual)
      MODO_NORMAL:  sig = MODO_SET_HOR;
      MODO_SET_HOR: sig = MODO_SET_MIN;
      MODO_SET_MIN: sig = MODO_NORMAL;
      default:      sig = MODO_NORMAL;
    endcase
    return sig;
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop synchronizer plus registered rising-edge detector for one button;
// the event pulse appears three clock edges after the input first rises.
module detector_flanco (
  input  logic clock,
  input  logic reset,
  input  logic boton,
  output logic evento
);

  logic sync1;
  logic sync2;
  logic previo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      previo <= 1'b0;
      evento <= 1'b0;
    end else begin
      sync1  <= boton;
      sync2  <= sync1;
      previo <= sync2;
      evento <= sync2 & ~previo;
    end
  end

endmodule

// File: rtl/control_reloj.sv
// Clock control: 1 Hz prescaler, mode FSM (NORMAL/SET_HOR/SET_MIN), increment
// and clear pulses for the time counters, and the blink enable for setting.
module control_reloj
  import reloj_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnModo,
  input  logic       btnInc,
  input  logic [5:0] segundos,
  input  logic [5:0] minutos,
  output logic       incSeg,
  output logic       incMin,
  output logic       incHor,
  output logic       clrSeg,
  output logic [1:0] modo,
  output logic       parpadeo,
  output logic       tick1Hz
);

  localparam int PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BLINK_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] BLINK_MAX = PRE_W'(BLINK_HALF - 1);
  localparam logic [PRE_W-1:0] UNO       = PRE_W'(1);

  logic             ev_modo;
  logic             ev_inc;
  modo_t            modo_q;
  logic [PRE_W-1:0] prescaler;
  logic [PRE_W-1:0] blink_cnt;
  logic             en_hora;
  logic             fin_seg;
  logic             fin_min;

  detector_flanco u_det_modo (
    .clock  (clock),
    .reset  (reset),
    .boton  (btnModo),
    .evento (ev_modo)
  );

  detector_flanco u_det_inc (
    .clock  (clock),
    .reset  (reset),
    .boton  (btnInc),
    .evento (ev_inc)
  );

  // Prescaler is held at 0 outside NORMAL, so the tick can only fire while running.
  assign en_hora = (modo_q == MODO_NORMAL);
  assign tick1Hz = en_hora && (prescaler == PRE_MAX);
  assign fin_seg = (segundos == SEG_MAX);
  assign fin_min = (minutos == MIN_MAX);
  assign modo    = modo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      modo_q    <= MODO_NORMAL;
      prescaler <= '0;
      incSeg    <= 1'b0;
      incMin    <= 1'b0;
      incHor    <= 1'b0;
      clrSeg    <= 1'b0;
    end else begin
      incSeg <= 1'b0;
      incMin <= 1'b0;
      incHor <= 1'b0;
      clrSeg <= 1'b0;
      case (modo_q)
        MODO_NORMAL: begin
          if (tick1Hz) begin
            incSeg <= 1'b1;
            incMin <= fin_seg;
            incHor <= fin_seg && fin_min;
          end
          if (ev_modo) begin
            modo_q    <= siguiente_modo(modo_q);
            prescaler <= '0;
          end else if (tick1Hz) begin
            prescaler <= '0;
          end else begin
            prescaler <= prescaler + UNO;
          end
        end
        MODO_SET_HOR: begin
          prescaler <= '0;
          // A simultaneous mode event wins; the increment is dropped.
          if (ev_modo) begin
            modo_q <= siguiente_modo(modo_q);
          end else if (ev_inc) begin
            incHor <= 1'b1;
          end
        end
        MODO_SET_MIN: begin
          prescaler <= '0;
          if (ev_modo) begin
            modo_q <= siguiente_modo(modo_q);
            clrSeg <= 1'b1;
          end else if (ev_inc) begin
            incMin <= 1'b1;
          end
        end
        default: begin
          modo_q    <= MODO_NORMAL;
          prescaler <= '0;
        end
      endcase
    end
  end

  // Blink restarts high on every mode change and toggles every BLINK_HALF cycles while setting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      parpadeo  <= 1'b1;
    end else if (ev_modo || modo_q == MODO_NORMAL || modo_q == MODO_INVALID) begin
      blink_cnt <= '0;
      parpadeo  <= 1'b1;
    end else if (blink_cnt == BLINK_MAX) begin
      blink_cnt <= '0;
      parpadeo  <= ~parpadeo;
    end else begin
      blink_cnt <= blink_cnt + UNO;
    end
  end

endmodule

// File: tb/tb_control_reloj.sv
// Self-checking bench for control_reloj at CLK_HZ=8: cycle-level reference
// model plus directed and randomized button/counter scenarios.
module tb_control_reloj;

  localparam int CLK_HZ = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       btnModo = 1'b0;
  logic       btnInc = 1'b0;
  logic [5:0] segundos = 6'd0;
  logic [5:0] minutos = 6'd0;
  logic       incSeg, incMin, incHor, clrSeg, parpadeo, tick1Hz;
  logic [1:0] modo;

  control_reloj #(.CLK_HZ(CLK_HZ)) dut (
    .clock    (clock),
    .reset    (reset),
    .btnModo  (btnModo),
    .btnInc   (btnInc),
    .segundos (segundos),
    .minutos  (minutos),
    .incSeg   (incSeg),
    .incMin   (incMin),
    .incHor   (incHor),
    .clrSeg   (clrSeg),
    .modo     (modo),
    .parpadeo (parpadeo),
    .tick1Hz  (tick1Hz)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: modes as integers, time measured as cycles since the
  // last mode entry, buttons as a history of sampled levels.
  int       m_mode = 0;
  int       t_norm = 0;
  int       t_set = 0;
  bit [3:0] hm = '0;
  bit [3:0] hi = '0;
  bit       e_incSeg = 0, e_incMin = 0, e_incHor = 0, e_clr = 0;
  bit       e_tick = 0, e_parp = 1;

  always @(posedge clock or posedge reset) begin
    bit mev, iev, tick_prev, s59, m59;
    if (reset) begin
      m_mode = 0; t_norm = 0; t_set = 0; hm = '0; hi = '0;
      e_incSeg = 0; e_incMin = 0; e_incHor = 0; e_clr = 0;
      e_tick = 0; e_parp = 1;
    end else begin
      // A button rise first sampled at edge k acts on the state at edge k+3.
      mev = hm[2] && !hm[3];
      iev = hi[2] && !hi[3];
      s59 = (segundos == 6'd59);
      m59 = (minutos == 6'd59);
      tick_prev = (m_mode == 0) && (t_norm % CLK_HZ == CLK_HZ - 1);
      e_incSeg = tick_prev;
      e_incMin = (tick_prev && s59) || (m_mode == 2 && iev && !mev);
      e_incHor = (tick_prev && s59 && m59) || (m_mode == 1 && iev && !mev);
      e_clr = (m_mode == 2) && mev;
      if (mev) begin
        m_mode = (m_mode + 1) % 3;
        t_norm = 0;
        t_set = 0;
      end else begin
        t_norm++;
        t_set++;
      end
      e_tick = (m_mode == 0) && (t_norm % CLK_HZ == CLK_HZ - 1);
      e_parp = (m_mode == 0) ? 1'b1 : ((t_set / (CLK_HZ / 4)) % 2 == 0);
      hm = {hm[2:0], btnModo};
      hi = {hi[2:0], btnInc};
    end
  end

  // Per-cycle scoreboard against the model, plus pulse counters for scenarios.
  bit chk_en = 0;
  int c_seg = 0, c_min = 0, c_hor = 0, c_clr = 0, c_tick = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      check("modo", modo, m_mode);
      check("incSeg", incSeg, e_incSeg);
      check("incMin", incMin, e_incMin);
      check("incHor", incHor, e_incHor);
      check("clrSeg", clrSeg, e_clr);
      check("tick1Hz", tick1Hz, e_tick);
      check("parpadeo", parpadeo, e_parp);
    end
    c_seg += incSeg; c_min += incMin; c_hor += incHor;
    c_clr += clrSeg; c_tick += tick1Hz;
  end

  task automatic zero_counts();
    @(negedge clock); #1;
    c_seg = 0; c_min = 0; c_hor = 0; c_clr = 0; c_tick = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic press(input bit pm, input bit pi, input int hold);
    @(negedge clock); #1;
    btnModo = pm;
    btnInc = pi;
    cycles(hold);
    btnModo = 0;
    btnInc = 0;
    cycles(5);
  endtask

  // Cycles counted from the current cycle (as 1) to the first tick1Hz; -1 if none.
  task automatic cycles_to_tick(output int n);
    n = -1;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clock);
      if (tick1Hz) begin
        n = i;
        break;
      end
    end
    #1;
  endtask

  initial begin
    int n;
    bit found;
    reset = 1'b1;
    @(posedge clock);
    chk_en = 1;
    cycles(2);
    check("rst_modo", modo, 0);
    check("rst_parpadeo", parpadeo, 1);
    check("rst_pulses", {incSeg, incMin, incHor, clrSeg, tick1Hz}, 0);
    reset = 1'b0;

    // NORMAL: first tick in the 8th cycle after release, then every 8 cycles.
    segundos = 6'($urandom_range(0, 58));
    cycles_to_tick(n);
    check("first_tick_cycles", n, CLK_HZ);
    zero_counts();
    for (int i = 0; i < 40; i++) begin
      segundos = 6'($urandom_range(0, 58));
      minutos = 6'($urandom_range(0, 59));
      cycles(1);
    end
    check("tick_count_40", c_tick, 5);
    check("incSeg_eq_ticks", c_seg, c_tick);
    check("no_incMin_below_59", c_min, 0);

    // Full carry: 59:59 at the tick pulses all three in one cycle.
    segundos = 6'd59;
    minutos = 6'd59;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (incSeg) begin
        found = 1;
        check("carry_incMin", incMin, 1);
        check("carry_incHor", incHor, 1);
      end
    end
    check("carry_seen", found, 1);
    @(negedge clock);
    check("carry_one_cycle", {incSeg, incMin, incHor}, 0);
    #1;
    segundos = 6'd10;
    minutos = 6'd20;

    // Mode button: modo=1 on the 4th edge after the rise.
    @(negedge clock); #1;
    btnModo = 1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("modo_after_4", modo, 1);
    #1;
    btnModo = 0;
    cycles(4);
    zero_counts();
    for (int i = 0; i < 3; i++) begin
      press(0, 1, $urandom_range(1, 3));
      cycles($urandom_range(0, 3));
    end
    check("sethor_incHor_3", c_hor, 3);
    check("sethor_incSeg_0", c_seg, 0);
    check("sethor_incMin_0", c_min, 0);

    // SET_MIN at 59: increment without carry, then exit clears seconds.
    press(1, 0, 2);
    check("modo_setmin", modo, 2);
    minutos = 6'd59;
    zero_counts();
    press(0, 1, 1);
    check("setmin_incMin", c_min, 1);
    check("setmin_no_incHor", c_hor, 0);
    @(negedge clock); #1;
    btnModo = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (i == 1) btnModo = 0;
      if (clrSeg) found = 1;
    end
    check("clrSeg_seen", found, 1);
    check("exit_modo", modo, 0);
    cycles_to_tick(n);
    check("tick_after_exit", n, CLK_HZ);
    check("clrSeg_once", c_clr, 1);

    // Simultaneous mode and increment in SET_HOR: mode wins.
    press(1, 0, 1);
    check("modo_sethor2", modo, 1);
    zero_counts();
    press(1, 1, 2);
    check("both_modo", modo, 2);
    check("both_no_incHor", c_hor, 0);
    check("both_no_incMin", c_min, 0);
    press(1, 0, 1);

    // Randomized traffic; the per-cycle model checks every output.
    for (int i = 0; i < 40; i++) begin
      segundos = 6'($urandom_range(55, 59));
      minutos = 6'($urandom_range(57, 59));
      case ($urandom_range(0, 3))
        0: press(1, 0, $urandom_range(1, 3));
        1: press(0, 1, $urandom_range(1, 3));
        2: press(1, 1, 1);
        default: cycles($urandom_range(1, 12));
      endcase
    end

    // Async reset in the middle of SET_HOR.
    for (int i = 0; i < 3 && m_mode != 1; i++) press(1, 0, 1);
    check("pre_reset_sethor", modo, 1);
    segundos = 6'd3;
    minutos = 6'd4;
    cycles(3);
    zero_counts();
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("async_modo", modo, 0);
    check("async_parpadeo", parpadeo, 1);
    check("async_pulses", {incSeg, incMin, incHor, clrSeg, tick1Hz}, 0);
    cycles(3);
    reset = 1'b0;
    cycles(6);
    check("post_reset_incHor", c_hor, 0);
    check("post_reset_incMin", c_min, 0);
    check("post_reset_incSeg", c_seg, 0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
